// File: rtl/bridge_arbiter.sv
// Round-robin arbiter that locks one of K sources onto the bridge input for BEATS accepted beats.
// Latency: data/valid/ready forwarded combinationally; one bubble cycle on a grant taken from IDLE.
// Backpressure: rdy_i reaches only the owner's req_rdy_o; a stall freezes the beat count and holds the grant.
module bridge_arbiter #(
    parameter int N     = 4,
    parameter int K     = 4,
    parameter int BEATS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [K-1:0]         req_vld_i,
    input  logic [K*N-1:0]       req_din,
    output logic [K-1:0]         req_rdy_o,
    output logic                 vld_o,
    output logic [N-1:0]         dout,
    input  logic                 rdy_i,
    output logic [$clog2(K)-1:0] gnt_id_o,
    output logic                 busy_o
);

    localparam int IW = $clog2(K);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   gnt, gnt_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IW:0]     pick_idle, pick_last;
    logic [N-1:0]    sel_dat;
    logic            beat;

    // Returns {found, index} of the first requester after ptr, wrapping modulo K.
    // The loop runs from the farthest offset down so the nearest requester wins.
    function automatic logic [IW:0] rr_pick(input logic [K-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int off = K; off >= 1; off--) begin
            idx = (int'(ptr) + off) % K;
            if (req[IW'(idx)]) begin
                res = {1'b1, IW'(idx)};
            end
        end
        return res;
    endfunction

    assign pick_idle = rr_pick(req_vld_i, last);
    assign pick_last = rr_pick(req_vld_i, gnt);

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < K; i++) begin
            if (gnt == IW'(i)) begin
                sel_dat = req_din[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= IW'(K - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        cnt_nxt   = cnt;
        vld_o     = 1'b0;
        dout      = '0;
        req_rdy_o = '0;
        busy_o    = 1'b0;
        gnt_id_o  = '0;
        beat      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_idle[IW]) begin
                    gnt_nxt   = pick_idle[IW-1:0];
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                vld_o          = req_vld_i[gnt];
                dout           = sel_dat;
                req_rdy_o[gnt] = rdy_i;
                busy_o         = 1'b1;
                gnt_id_o       = gnt;
                beat           = req_vld_i[gnt] && rdy_i;
                if (beat) begin
                    if (cnt == CW'(BEATS - 1)) begin
                        // Burst complete: the pointer advances past the owner before re-picking.
                        last_nxt = gnt;
                        if (pick_last[IW]) begin
                            gnt_nxt = pick_last[IW-1:0];
                            cnt_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Self-checking bench for bridge_arbiter: expected beats are queued as stimulus is set up
// and popped as the arbiter forwards accepted beats.
module tb_bridge_arbiter;

    localparam int N     = 4;
    localparam int K     = 4;
    localparam int BEATS = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [K-1:0]   req_vld;
    logic [K*N-1:0] req_din;
    logic [K-1:0]   req_rdy_o;
    logic           vld_o;
    logic [N-1:0]   dout;
    logic           rdy;
    logic [1:0]     gnt_id_o;
    logic           busy_o;

    typedef struct { int id; int dat; } exp_t;
    typedef struct { logic b; logic v; int id; int d; logic [K-1:0] rr; logic bz; } obs_t;

    exp_t q[$];
    int   seq[K];
    int   exp_seq[K];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < K; i++) begin
            req_din[i*N +: N] = seq[i][N-1:0];
        end
    end

    bridge_arbiter #(.N(N), .K(K), .BEATS(BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld_i (req_vld),
        .req_din   (req_din),
        .req_rdy_o (req_rdy_o),
        .vld_o     (vld_o),
        .dout      (dout),
        .rdy_i     (rdy),
        .gnt_id_o  (gnt_id_o),
        .busy_o    (busy_o)
    );

    // One clock: sample outputs on the falling edge, then advance source data for accepted beats.
    task automatic cyc(output obs_t o);
        logic [K-1:0] acc;
        @(negedge clk);
        o.b  = vld_o && rdy;
        o.v  = vld_o;
        o.id = int'(gnt_id_o);
        o.d  = int'(dout);
        o.rr = req_rdy_o;
        o.bz = busy_o;
        acc  = req_rdy_o & req_vld;
        @(posedge clk);
        #1;
        for (int i = 0; i < K; i++) begin
            if (acc[i]) seq[i]++;
        end
    endtask

    task automatic push_exp(input int id);
        q.push_back('{id, exp_seq[id] % 16});
        exp_seq[id]++;
    endtask

    task automatic start_test();
        q.delete();
        for (int i = 0; i < K; i++) exp_seq[i] = seq[i];
    endtask

    task automatic get_exp(output logic ok, output exp_t e);
        ok = (q.size() > 0);
        e  = '{-1, -1};
        if (ok) e = q.pop_front();
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        req_vld = '0;
        rdy     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n   = 1'b0;
        req_vld = '0;
        rdy     = 1'b0;
        for (int i = 0; i < K; i++) seq[i] = 0;
        #2;
        total++;
        if ({vld_o, busy_o, req_rdy_o, dout, gnt_id_o} !== '0) begin
            bad++;
            $display("FAIL reset_values: vld=%b busy=%b rdy=%b dout=%0d gnt=%0d want all 0",
                     vld_o, busy_o, req_rdy_o, dout, gnt_id_o);
        end
        #18;
        rst_n = 1'b1;
        rdy   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc(o);
            total++;
            if (o.v !== 1'b0 || o.rr !== '0 || o.bz !== 1'b0) begin
                bad++;
                $display("FAIL idle_quiet c=%0d: vld=%b rdy=%b busy=%b want 0", c, o.v, o.rr, o.bz);
            end
        end
    endtask

    task automatic test_single_source();
        obs_t o;
        exp_t e;
        logic ok;
        reset_dut();
        seq[2] = 1;
        start_test();
        for (int k = 0; k < 12; k++) push_exp(2);
        rdy     = 1'b1;
        req_vld = 4'b0100;
        cyc(o);
        total++;
        if (o.v !== 1'b0) begin
            bad++;
            $display("FAIL single_bubble: vld=%b want 0", o.v);
        end
        for (int c = 0; c < 12; c++) begin
            cyc(o);
            get_exp(ok, e);
            total++;
            if (o.b !== 1'b1 || !ok || o.id !== e.id || o.d !== e.dat) begin
                bad++;
                $display("FAIL single_beat c=%0d: beat=%b id=%0d dat=%0d want beat=1 id=%0d dat=%0d",
                         c, o.b, o.id, o.d, e.id, e.dat);
            end
        end
        req_vld = '0;
    endtask

    task automatic test_round_robin();
        obs_t o;
        exp_t e;
        logic ok;
        reset_dut();
        start_test();
        for (int k = 0; k < 15; k++) push_exp((k / BEATS) % K);
        rdy     = 1'b1;
        req_vld = 4'b1111;
        cyc(o);
        total++;
        if (o.v !== 1'b0) begin
            bad++;
            $display("FAIL rr_bubble: vld=%b want 0", o.v);
        end
        for (int c = 0; c < 15; c++) begin
            cyc(o);
            get_exp(ok, e);
            total++;
            if (o.b !== 1'b1 || !ok || o.id !== e.id || o.d !== e.dat) begin
                bad++;
                $display("FAIL rr_beat c=%0d: beat=%b id=%0d dat=%0d want beat=1 id=%0d dat=%0d",
                         c, o.b, o.id, o.d, e.id, e.dat);
            end
        end
        req_vld = '0;
    endtask

    task automatic test_backpressure();
        obs_t o;
        exp_t e;
        logic ok;
        int   start[K];
        int   exp_cnt[K];
        int   beats;
        reset_dut();
        start_test();
        beats = 0;
        for (int i = 0; i < K; i++) begin
            start[i]   = seq[i];
            exp_cnt[i] = 0;
        end
        for (int k = 0; k < 24; k++) push_exp((k / BEATS) % K);
        req_vld = 4'b1111;
        for (int c = 0; c < 64; c++) begin
            rdy = ((c % 16) < 4);
            cyc(o);
            if (o.b) begin
                beats++;
                get_exp(ok, e);
                if (ok) exp_cnt[e.id]++;
                total++;
                if (!ok || o.id !== e.id || o.d !== e.dat) begin
                    bad++;
                    $display("FAIL bp_beat c=%0d: id=%0d dat=%0d want id=%0d dat=%0d",
                             c, o.id, o.d, e.id, e.dat);
                end
            end else if (o.bz && q.size() > 0) begin
                total++;
                if (o.id !== q[0].id || o.rr !== '0) begin
                    bad++;
                    $display("FAIL bp_stall c=%0d: id=%0d rdy=%b want id=%0d rdy=0",
                             c, o.id, o.rr, q[0].id);
                end
            end
        end
        total++;
        if (beats !== 15) begin
            bad++;
            $display("FAIL bp_beat_total: got %0d want 15", beats);
        end
        for (int i = 0; i < K; i++) begin
            total++;
            if (seq[i] - start[i] !== exp_cnt[i]) begin
                bad++;
                $display("FAIL bp_src_count src=%0d: got %0d want %0d", i, seq[i] - start[i], exp_cnt[i]);
            end
        end
        req_vld = '0;
    endtask

    task automatic test_owner_stall();
        obs_t o;
        exp_t e;
        logic ok;
        reset_dut();
        start_test();
        for (int k = 0; k < 3; k++) push_exp(1);
        for (int k = 0; k < 3; k++) push_exp(3);
        rdy     = 1'b1;
        req_vld = 4'b0010;
        cyc(o);
        cyc(o);
        get_exp(ok, e);
        total++;
        if (o.b !== 1'b1 || !ok || o.id !== e.id || o.d !== e.dat) begin
            bad++;
            $display("FAIL stall_first: beat=%b id=%0d dat=%0d want beat=1 id=%0d dat=%0d",
                     o.b, o.id, o.d, e.id, e.dat);
        end
        req_vld = 4'b1000;
        for (int c = 0; c < 5; c++) begin
            cyc(o);
            total++;
            if (o.id !== 1 || o.v !== 1'b0 || o.bz !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold c=%0d: id=%0d vld=%b busy=%b want id=1 vld=0 busy=1",
                         c, o.id, o.v, o.bz);
            end
        end
        req_vld = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            cyc(o);
            get_exp(ok, e);
            total++;
            if (o.b !== 1'b1 || !ok || o.id !== e.id || o.d !== e.dat) begin
                bad++;
                $display("FAIL stall_resume c=%0d: beat=%b id=%0d dat=%0d want beat=1 id=%0d dat=%0d",
                         c, o.b, o.id, o.d, e.id, e.dat);
            end
        end
        req_vld = '0;
    endtask

    task automatic test_reset_mid_burst();
        obs_t o;
        exp_t e;
        logic ok;
        reset_dut();
        start_test();
        push_exp(0);
        push_exp(0);
        rdy     = 1'b1;
        req_vld = 4'b0001;
        cyc(o);
        for (int c = 0; c < 2; c++) begin
            cyc(o);
            get_exp(ok, e);
            total++;
            if (o.b !== 1'b1 || !ok || o.id !== e.id || o.d !== e.dat) begin
                bad++;
                $display("FAIL mid_pre c=%0d: beat=%b id=%0d dat=%0d want beat=1 id=%0d dat=%0d",
                         c, o.b, o.id, o.d, e.id, e.dat);
            end
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({vld_o, busy_o, req_rdy_o, dout, gnt_id_o} !== '0) begin
            bad++;
            $display("FAIL mid_async_reset: vld=%b busy=%b rdy=%b dout=%0d gnt=%0d want all 0",
                     vld_o, busy_o, req_rdy_o, dout, gnt_id_o);
        end
        start_test();
        for (int k = 0; k < 3; k++) push_exp(0);
        for (int k = 0; k < 3; k++) push_exp(3);
        req_vld = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            cyc(o);
            get_exp(ok, e);
            total++;
            if (o.b !== 1'b1 || !ok || o.id !== e.id || o.d !== e.dat) begin
                bad++;
                $display("FAIL mid_post c=%0d: beat=%b id=%0d dat=%0d want beat=1 id=%0d dat=%0d",
                         c, o.b, o.id, o.d, e.id, e.dat);
            end
        end
        req_vld = '0;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_owner_stall();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
